// File: rtl/ct_ifu_btb_tag_ctrl.sv
// BTB tag array controller: arbitrates sweep/update/lookup onto the tag SRAM pins
// and compares the registered lookup tag against the read data one cycle later.
`timescale 1ns/1ps

module ct_ifu_btb_tag_ctrl #(
  parameter  int SETS  = 512,
  parameter  int TAG_W = 10,
  localparam int IDX_W = $clog2(SETS),
  localparam int ENT_W = TAG_W + 1
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic                 inv_req,
  input  logic                 wr_vld,
  output logic                 wr_rdy,
  input  logic [IDX_W-1:0]     wr_index,
  input  logic [3:0]           wr_way,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic                 rd_vld,
  output logic                 rd_rdy,
  input  logic [IDX_W-1:0]     rd_index,
  input  logic [TAG_W-1:0]     rd_tag,
  input  logic [4*ENT_W-1:0]   btb_tag_dout,
  output logic [IDX_W:0]       btb_index,
  output logic                 btb_tag_cen_b,
  output logic                 btb_tag_clk_en,
  output logic [3:0]           btb_tag_wen,
  output logic [2*ENT_W-1:0]   btb_tag_din,
  output logic                 hit_vld,
  output logic [3:0]           hit_way,
  output logic                 hit,
  output logic                 multi_hit,
  output logic                 inv_busy
);

  typedef enum logic {INV, RUN} state_t;

  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] inv_cnt, inv_cnt_nxt;
  logic             wr_acc, rd_acc;
  logic             rd_pipe_q;
  logic [TAG_W-1:0] tag_q;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state   <= INV;
      inv_cnt <= '0;
    end else begin
      state   <= state_nxt;
      inv_cnt <= inv_cnt_nxt;
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      rd_pipe_q <= 1'b0;
      tag_q     <= '0;
    end else begin
      rd_pipe_q <= rd_acc;
      if (rd_acc) tag_q <= rd_tag;
    end
  end

  // A request on the final sweep set restarts rather than exiting.
  always_comb begin
    state_nxt   = state;
    inv_cnt_nxt = inv_cnt;
    case (state)
      INV: begin
        if (inv_req) begin
          inv_cnt_nxt = '0;
        end else if (inv_cnt == LAST_SET) begin
          state_nxt   = RUN;
          inv_cnt_nxt = '0;
        end else begin
          inv_cnt_nxt = inv_cnt + IDX_W'(1);
        end
      end
      RUN: begin
        if (inv_req) begin
          state_nxt   = INV;
          inv_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = INV;
        inv_cnt_nxt = '0;
      end
    endcase
  end

  // Reset gates the array pins combinationally so they idle while cpurst is high.
  always_comb begin
    wr_rdy         = 1'b0;
    rd_rdy         = 1'b0;
    wr_acc         = 1'b0;
    rd_acc         = 1'b0;
    inv_busy       = 1'b1;
    btb_index      = '0;
    btb_tag_cen_b  = 1'b1;
    btb_tag_clk_en = 1'b0;
    btb_tag_wen    = '1;
    btb_tag_din    = '0;
    if (!cpurst) begin
      case (state)
        INV: begin
          btb_index      = {1'b0, inv_cnt};
          btb_tag_cen_b  = 1'b0;
          btb_tag_clk_en = 1'b1;
          btb_tag_wen    = '0;
        end
        RUN: begin
          inv_busy = 1'b0;
          wr_rdy   = ~inv_req;
          rd_rdy   = ~inv_req & ~wr_vld;
          wr_acc   = wr_vld & wr_rdy;
          rd_acc   = rd_vld & rd_rdy;
          if (wr_acc) begin
            btb_index      = {1'b0, wr_index};
            btb_tag_cen_b  = 1'b0;
            btb_tag_clk_en = 1'b1;
            btb_tag_wen    = ~wr_way;
            btb_tag_din    = {2{1'b1, wr_tag}};
          end else if (rd_acc) begin
            btb_index      = {1'b0, rd_index};
            btb_tag_cen_b  = 1'b0;
            btb_tag_clk_en = 1'b1;
          end
        end
        default: begin
          inv_busy = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    logic [ENT_W-1:0] entry;
    entry   = '0;
    hit_vld = rd_pipe_q;
    hit_way = '0;
    if (rd_pipe_q) begin
      for (int unsigned n = 0; n < 4; n++) begin
        entry      = btb_tag_dout[n*ENT_W +: ENT_W];
        hit_way[n] = entry[TAG_W] && (entry[TAG_W-1:0] == tag_q);
      end
    end
    hit       = |hit_way;
    multi_hit = |(hit_way & (hit_way - 4'd1));
  end

endmodule

// File: doc/ct_ifu_btb_tag_ctrl.md
Name: ct_ifu_btb_tag_ctrl

Overview:
- Control and compare stage wrapped around the BTB tag SRAM: 2 banks × 2 ways, 11-bit entries, 512 sets.
- Upstream: arbitrates between invalidation sweeps, BTB update writes and fetch lookups, and drives the array's index, chip-enable, write-enable and data pins.
- Downstream: registers the lookup tag, compares it against the 44-bit array read data one cycle later, and produces the per-way hit vector for the IFU BTB hit logic.

Parameters:
- SETS, 512, number of sets swept by invalidation; index width is log2(SETS) = 9.
- TAG_W, 10, tag bits per way; each entry is {valid, tag[9:0]} = 11 bits.

Ports:
- forever_cpuclk  in  1  clock; same clock as the tag array gate cell input.
- cpurst  in  1  reset; asynchronous, active-high.
- inv_req  in  1  pulse; start (or restart) a full invalidation sweep.
- wr_vld  in  1  update write request.
- wr_rdy  out  1  update write accepted when wr_vld & wr_rdy.
- wr_index  in  9  write set.
- wr_way  in  4  one-hot target way.
- wr_tag  in  10  tag to write; the valid bit is written as 1.
- rd_vld  in  1  lookup request.
- rd_rdy  out  1  lookup accepted when rd_vld & rd_rdy.
- rd_index  in  9  lookup set.
- rd_tag  in  10  lookup tag.
- btb_tag_dout  in  44  array read data; way n occupies bits [11n+10:11n].
- btb_index  out  10  array address; bit 9 is always 0.
- btb_tag_cen_b  out  1  array chip enable, active-low.
- btb_tag_clk_en  out  1  array gate-clock local enable.
- btb_tag_wen  out  4  per-way write enable, active-low.
- btb_tag_din  out  22  write data = {entry, entry}.
- hit_vld  out  1  lookup result valid.
- hit_way  out  4  per-way hit.
- hit  out  1  |hit_way.
- multi_hit  out  1  more than one hit_way bit set.
- inv_busy  out  1  sweep in progress.

Behaviour:
- **States:** INV and RUN; 9-bit sweep counter inv_cnt.
- **Reset:** while cpurst is high, state = INV, inv_cnt = 0 and all outputs are idle:
  - btb_tag_cen_b = 1, btb_tag_clk_en = 0, btb_tag_wen = 4'hF, btb_index = 0, btb_tag_din = 0.
  - wr_rdy = 0, rd_rdy = 0, hit_vld = 0, hit_way = 0, hit = 0, multi_hit = 0, inv_busy = 1.
- **Sweep after reset:** the sweep starts on the first clock edge after cpurst deasserts. SRAM contents are undefined, so every reset forces a sweep.
- **INV:**
  - Each cycle: btb_index = {1'b0, inv_cnt}, cen_b = 0, wen = 4'h0, din = 0, clk_en = 1.
  - inv_cnt increments each cycle.
  - When inv_cnt = SETS-1 is written, go to RUN and clear inv_busy. A sweep is exactly 512 cycles.
  - wr_rdy = rd_rdy = 0 throughout INV.
- **inv_req:**
  - In RUN: enter INV next cycle with inv_cnt = 0. Any wr/rd presented in the same cycle is not accepted.
  - In INV: restart with inv_cnt = 0 on the next cycle.
  - Asserted on the last sweep cycle: restart, do not go to RUN.
- **RUN arbitration:** priority is inv_req > write > read. Array outputs are combinational from the winning request, one access per cycle.
  - **Write:** wr_rdy = ~inv_req. On accept:
    - btb_index = {0, wr_index}, cen_b = 0, clk_en = 1.
    - wen[n] = ~wr_way[n].
    - din = {2{1'b1, wr_tag}}.
  - **Read:** rd_rdy = ~inv_req & ~wr_vld. On accept:
    - btb_index = {0, rd_index}, cen_b = 0, wen = 4'hF, clk_en = 1.
    - rd_tag is registered into tag_q; a 1-cycle valid pipe flag is set.
  - **Idle:** cen_b = 1, clk_en = 0, wen = 4'hF.
- **Compare (cycle after read accept):**
  - hit_vld = 1.
  - hit_way[n] = dout[11n+10] & (dout[11n+9:11n] == tag_q).
  - hit and multi_hit are combinational from hit_way.
  - hit_way, hit and multi_hit are forced to 0 whenever hit_vld = 0.
- **Pipelined reads:** back-to-back reads produce one result per cycle.
- **Write after read:** a write the cycle after a read does not disturb that read's result.
- **inv_req with a result pending:** the pending result still issues (hit_vld = 1) on the cycle inv_req is seen.
- **Multi-hit:** hit_way reports all matching ways; no masking.

Test Plan:
- Reset release → 512 consecutive cycles of cen_b = 0, wen = 0, index 0..511; inv_busy falls after index 511; rd_rdy rises the same cycle.
- Write set 0x05, way 4'b0100, tag 0x2AB; then read set 0x05 with tag 0x2AB.
  - Write cycle: wen = 4'b1011, din = {2{11'h6AB}}.
  - Read result one cycle later: hit_way = 4'b0100, hit = 1.
- Simultaneous wr_vld and rd_vld → write issues, rd_rdy = 0; read issues the next cycle.
- Write the same tag 0x011 to ways 0 and 3 of set 0x1FF, then look up 0x011 → hit_way = 4'b1001, multi_hit = 1.
- inv_req at sweep count 200 → index returns to 0 next cycle; a full 512 further cycles complete before RUN.
- cpurst asserted mid-sweep and mid-read → outputs go to reset values immediately and hit_vld = 0; after release, the sweep restarts at index 0.
